// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with mid-bit sampling, PLL-lock gating and a
// valid/ready output register that flags overruns and framing errors.
module uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 60000000,
    parameter int unsigned BAUD        = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_cfg_check
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Stop,
        WaitIdle
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic            rx_s;
    logic [CntW-1:0] cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            byte_done;

    assign rx_s = sync[1];

    // Receive FSM. Dropping lock_i abandons any frame in progress without
    // touching the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= 2'b11;
            state       <= Idle;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            byte_done   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_i};
            byte_done   <= 1'b0;
            frame_err_o <= 1'b0;
            if (!lock_i) begin
                state <= Idle;
                cnt   <= '0;
            end else begin
                case (state)
                    Idle: begin
                        if (!rx_s) begin
                            state <= Start;
                            cnt   <= '0;
                        end
                    end
                    Start: begin
                        if (cnt == CntHalf) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state <= Data;
                                idx   <= '0;
                            end else begin
                                state <= Idle;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    Data: begin
                        if (cnt == CntBit) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[7:1]};
                            idx   <= idx + 1'b1;
                            if (idx == 3'd7) begin
                                state <= Stop;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    Stop: begin
                        if (cnt == CntBit) begin
                            cnt <= '0;
                            if (rx_s) begin
                                byte_done <= 1'b1;
                                state     <= Idle;
                            end else begin
                                frame_err_o <= 1'b1;
                                state       <= WaitIdle;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WaitIdle: begin
                        // Hold off until the line returns high so a break is
                        // not decoded as a train of zero frames.
                        if (rx_s) begin
                            state <= Idle;
                        end
                    end
                    default: state <= Idle;
                endcase
            end
        end
    end

    // Output register: a completed byte is loaded only if the slot is free or
    // being consumed this cycle; otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o    <= 8'h00;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (byte_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario-driven bench for uart_rx: serial frames are generated at bit level
// and results are compared with expectations computed from the frame contents.
module tb_uart_rx;

    localparam int unsigned ClkHz = 3686400;
    localparam int unsigned Baud  = 115200;
    localparam int          Cpb   = ClkHz / Baud;
    localparam int          Half  = Cpb / 2;
    localparam int          Lat   = 2 + 1 + Half + 8 * Cpb + Cpb + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       frame_err_o;
    logic       overrun_o;

    uart_rx #(
        .CLK_FREQ_HZ(ClkHz),
        .BAUD       (Baud)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock_i     (lock_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int err_cnt = 0;
    int ovr_cnt = 0;
    int vhigh_cnt = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted bytes and pulses away from the active edge.
    always @(negedge clk) begin
        if (valid_o === 1'b1 && ready_i === 1'b1) got.push_back(data_o);
        if (frame_err_o === 1'b1) err_cnt++;
        if (overrun_o === 1'b1) ovr_cnt++;
        if (valid_o === 1'b1 && valid_prev !== 1'b1 && rise_cyc < 0) rise_cyc = cyc;
        if (valid_o === 1'b1) vhigh_cnt++;
        valid_prev = valid_o;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        err_cnt   = 0;
        ovr_cnt   = 0;
        vhigh_cnt = 0;
        rise_cyc  = -1;
    endtask

    // Leaves the line at the stop-bit level; callers restore idle if needed.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        start_cyc = cyc;
        wait_cycles(Cpb);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_cycles(Cpb);
        end
        rx_i = stop;
        wait_cycles(Cpb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        n_tests++;
        if (data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h, expected 00", data_o);
        end
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid_o);
        end
        n_tests++;
        if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got ferr=%b ovr=%b, expected 0 0", frame_err_o, overrun_o);
        end
        rst = 1'b0;
        wait_cycles(2 * Cpb);
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: got %b, expected 0", valid_o);
        end
    endtask

    task automatic test_latency();
        ready_i = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (rise_cyc - start_cyc < Lat - 1 || rise_cyc - start_cyc > Lat + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, expected %0d", rise_cyc - start_cyc, Lat);
        end
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL latency_data: got %0d bytes first %h, expected 1 byte A5",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        n_tests++;
        if (vhigh_cnt != 1) begin
            n_fail++; $display("FAIL latency_valid_len: got %0d cycles, expected 1", vhigh_cnt);
        end
        n_tests++;
        if (err_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL latency_pulses: got ferr=%0d ovr=%0d, expected 0 0",
                               err_cnt, ovr_cnt);
        end
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        clear_mon();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (data_o !== 8'h3C || valid_o !== 1'b1) begin
            n_fail++; $display("FAIL overrun_hold: got data=%h valid=%b, expected 3C 1",
                               data_o, valid_o);
        end
        n_tests++;
        if (ovr_cnt != 1) begin
            n_fail++; $display("FAIL overrun_pulse: got %0d pulses, expected 1", ovr_cnt);
        end
        ready_i = 1'b1;
        wait_cycles(1);
        ready_i = 1'b0;
        wait_cycles(1);
        n_tests++;
        if (valid_o !== 1'b0 || got.size() != 1 || got[0] !== 8'h3C) begin
            n_fail++; $display("FAIL overrun_drain: got valid=%b accepted=%0d, expected 0 and 1 (3C)",
                               valid_o, got.size());
        end
    endtask

    task automatic test_frame_err();
        ready_i = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        wait_cycles(3 * Cpb);
        rx_i = 1'b1;
        wait_cycles(Cpb);
        n_tests++;
        if (err_cnt != 1 || vhigh_cnt != 0) begin
            n_fail++; $display("FAIL frame_err_pulse: got ferr=%0d valid_cycles=%0d, expected 1 0",
                               err_cnt, vhigh_cnt);
        end
        send_frame(8'h12, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'h12 || err_cnt != 1) begin
            n_fail++; $display("FAIL frame_err_recover: got %0d bytes ferr=%0d, expected 1 byte 12, ferr 1",
                               got.size(), err_cnt);
        end
    endtask

    task automatic test_glitch();
        ready_i = 1'b1;
        clear_mon();
        rx_i = 1'b0;
        wait_cycles(Half / 2);
        rx_i = 1'b1;
        wait_cycles(2 * Cpb);
        n_tests++;
        if (vhigh_cnt != 0 || err_cnt != 0 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL glitch_quiet: got valid=%0d ferr=%0d ovr=%0d, expected 0 0 0",
                               vhigh_cnt, err_cnt, ovr_cnt);
        end
        send_frame(8'h81, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'h81) begin
            n_fail++; $display("FAIL glitch_next: got %0d bytes, expected 1 byte 81", got.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] partial;
        ready_i = 1'b0;
        send_frame(8'($urandom), 1'b1);
        wait_cycles(4);
        // Upper nibble high so the tail of the aborted frame cannot look like a start bit.
        partial = 8'hF0 | 8'($urandom_range(0, 15));
        fork
            send_frame(partial, 1'b1);
            begin
                wait_cycles(5 * Cpb + Half);
                rst = 1'b1;
                wait_cycles(1);
                rst = 1'b0;
                n_tests++;
                if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0
                    || overrun_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midframe_rst: got valid=%b data=%h ferr=%b ovr=%b, expected 0 00 0 0",
                             valid_o, data_o, frame_err_o, overrun_o);
                end
            end
        join
        wait_cycles(Cpb);
        ready_i = 1'b1;
        clear_mon();
        send_frame(8'h7E, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'h7E) begin
            n_fail++; $display("FAIL midframe_next: got %0d bytes, expected 1 byte 7E", got.size());
        end
    endtask

    task automatic test_lock_drop();
        logic [7:0] held;
        held = 8'($urandom);
        ready_i = 1'b0;
        clear_mon();
        send_frame(held, 1'b1);
        wait_cycles(4);
        fork
            send_frame(8'($urandom), 1'b1);
            begin
                wait_cycles(3 * Cpb + Half);
                lock_i = 1'b0;
            end
        join
        wait_cycles(Cpb);
        lock_i = 1'b1;
        wait_cycles(2);
        n_tests++;
        if (data_o !== held || valid_o !== 1'b1 || ovr_cnt != 0) begin
            n_fail++; $display("FAIL lock_hold: got data=%h valid=%b ovr=%0d, expected %h 1 0",
                               data_o, valid_o, ovr_cnt, held);
        end
        ready_i = 1'b1;
        send_frame(8'hF0, 1'b1);
        wait_cycles(4);
        n_tests++;
        if (got.size() != 2 || got[0] !== held || got[1] !== 8'hF0) begin
            n_fail++; $display("FAIL lock_next: got %0d bytes, expected 2 (%h, F0)", got.size(), held);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int exp_err;
        logic [7:0] b;
        logic bad;
        exp_err = 0;
        ready_i = 1'b1;
        clear_mon();
        for (int f = 0; f < 12; f++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(b, !bad);
            if (bad) begin
                exp_err++;
                rx_i = 1'b1;
                wait_cycles($urandom_range(2, Cpb));
            end else begin
                exp_q.push_back(b);
                wait_cycles($urandom_range(0, 2));
            end
        end
        wait_cycles(4);
        n_tests++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d bytes, expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %h, expected %h", i, got[i], exp_q[i]);
            end
        end
        n_tests++;
        if (err_cnt != exp_err || ovr_cnt != 0) begin
            n_fail++; $display("FAIL b2b_pulses: got ferr=%0d ovr=%0d, expected %0d 0",
                               err_cnt, ovr_cnt, exp_err);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_lock_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
